ram_16x8: RTL and testbench

RAM_16X8 -- requirements
Module: ram_16x8

---
 rtl/ram_16x8_if.sv | 24 ++
 rtl/ram_16x8.sv | 53 +++++
 tb/tb_ram_16x8.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ram_16x8_if.sv
// ram_16x8_if: write/read request bus for ram_16x8.
// Master drives write, read, WriteAddr, ReadAddr and WriteData.
// Slave drives ReadData, WriteReady and ReadReady.
interface ram_16x8_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] WriteAddr;
    logic [ADDR_W-1:0] ReadAddr;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              WriteReady;
    logic              ReadReady;
    modport master (
        output write, read, WriteAddr, ReadAddr, WriteData,
        input  ReadData, WriteReady, ReadReady
    );
    modport slave (
        input  write, read, WriteAddr, ReadAddr, WriteData,
        output ReadData, WriteReady, ReadReady
    );
endinterface

// File: rtl/ram_16x8.sv
// ram_16x8: 2**ADDR_W x DATA_W RAM with independent one-shot write and read ports.
// Ports: clock (rising edge), reset (async, active high), bus (ram_16x8_if.slave).
// A held write stores one word; a read returns the pre-write word on a same-edge collision.
module ram_16x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic       clock,
    input logic       reset,
    ram_16x8_if.slave bus
);
    typedef enum logic {W_IDLE, W_BUSY} w_state_t;
    typedef enum logic {R_IDLE, R_DONE} r_state_t;
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    w_state_t          w_q, w_d;
    r_state_t          r_q, r_d;
    logic              w_en, r_en;
    always_comb begin
        w_en = (w_q == W_IDLE) && bus.write;
        w_d  = bus.write ? W_BUSY : W_IDLE;
        r_en = (r_q == R_IDLE) && bus.read;
        r_d  = bus.read ? R_DONE : R_IDLE;
    end
    // Reset parks the write FSM in W_BUSY so WriteReady rises only after a write-low edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_q <= W_BUSY;
            r_q <= R_IDLE;
        end else begin
            w_q <= w_d;
            r_q <= r_d;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if (w_en) begin
            mem_q[bus.WriteAddr] <= bus.WriteData;
        end
    end
    // Sampling mem_q on the same edge as a write yields the old word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (r_en) begin
            rdata_q <= mem_q[bus.ReadAddr];
        end
    end
    assign bus.ReadData   = rdata_q;
    assign bus.WriteReady = (w_q == W_IDLE);
    assign bus.ReadReady  = (r_q == R_DONE);
endmodule

// File: tb/tb_ram_16x8.sv
// tb_ram_16x8: scoreboard bench for ram_16x8 with directed vectors.
module tb_ram_16x8;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;
    logic [7:0] model [16];
    logic [7:0] exp_q [$];
    logic       rr_prev = 1'b0;
    ram_16x8_if #(.DATA_W(8), .ADDR_W(4)) bus ();
    ram_16x8 #(.DATA_W(8), .ADDR_W(4)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    always @(negedge clock) begin
        if (bus.ReadReady && !rr_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_read: got %0h expected no read", bus.ReadData);
            end else begin
                check("read_data", {24'd0, bus.ReadData}, {24'd0, exp_q.pop_front()});
            end
        end
        rr_prev <= bus.ReadReady;
    end
    task automatic idle();
        @(negedge clock);
        bus.write = 1'b0;
        bus.read  = 1'b0;
    endtask
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.write = 1'b1; bus.WriteAddr = a; bus.WriteData = d;
        model[a] = d;
        idle();
        @(negedge clock);
    endtask
    task automatic rd(input logic [3:0] a);
        @(negedge clock);
        bus.read = 1'b1; bus.ReadAddr = a;
        exp_q.push_back(model[a]);
        idle();
        @(negedge clock);
    endtask
    task automatic both(input logic [3:0] wa, input logic [7:0] wd, input logic [3:0] ra);
        @(negedge clock);
        bus.write = 1'b1; bus.WriteAddr = wa; bus.WriteData = wd;
        bus.read = 1'b1; bus.ReadAddr = ra;
        exp_q.push_back(model[ra]);
        model[wa] = wd;
        idle();
        @(negedge clock);
    endtask
    initial begin
        bus.write = 1'b0; bus.read = 1'b0;
        bus.WriteAddr = '0; bus.ReadAddr = '0; bus.WriteData = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        #2 reset = 1'b1;
        @(negedge clock);
        check("rst_wready", {31'd0, bus.WriteReady}, 0);
        check("rst_rready", {31'd0, bus.ReadReady}, 0);
        check("rst_rdata", {24'd0, bus.ReadData}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_wready", {31'd0, bus.WriteReady}, 1);
        check("post_rst_rready", {31'd0, bus.ReadReady}, 0);
        rd(4'd5);
        rd(4'd15);
        @(negedge clock);
        check("w3_ready_before", {31'd0, bus.WriteReady}, 1);
        bus.write = 1'b1; bus.WriteAddr = 4'd3; bus.WriteData = 8'hA5;
        model[3] = 8'hA5;
        @(negedge clock);
        check("w3_ready_busy", {31'd0, bus.WriteReady}, 0);
        bus.write = 1'b0;
        @(negedge clock);
        check("w3_ready_back", {31'd0, bus.WriteReady}, 1);
        @(negedge clock);
        bus.read = 1'b1; bus.ReadAddr = 4'd3;
        exp_q.push_back(8'hA5);
        @(negedge clock);
        check("r3_ready", {31'd0, bus.ReadReady}, 1);
        bus.read = 1'b0;
        @(negedge clock);
        check("r3_ready_drop", {31'd0, bus.ReadReady}, 0);
        check("r3_data_hold", {24'd0, bus.ReadData}, 32'hA5);
        @(negedge clock);
        bus.write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.WriteAddr = 4'(8 + i); bus.WriteData = 8'(8'h11 * (i + 1));
            @(negedge clock);
            check("held_wready", {31'd0, bus.WriteReady}, 0);
        end
        model[8] = 8'h11;
        bus.write = 1'b0;
        @(negedge clock);
        check("held_wready_back", {31'd0, bus.WriteReady}, 1);
        for (int i = 8; i < 13; i++) rd(4'(i));
        both(4'd7, 8'h5A, 4'd7);
        rd(4'd7);
        for (int i = 0; i < 17; i++) both(4'(i), 8'(i * 37 + 11), 4'((i + 9) % 16));
        rd(4'd0);
        rd(4'd15);
        rd(4'd9);
        @(negedge clock);
        bus.write = 1'b1; bus.WriteAddr = 4'd3; bus.WriteData = 8'hC3;
        #2 reset = 1'b1;
        #1 check("mid_rst_wready", {31'd0, bus.WriteReady}, 0);
        check("mid_rst_rdata", {24'd0, bus.ReadData}, 0);
        bus.write = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        @(negedge clock);
        rd(4'd3);
        rd(4'd7);
        repeat (3) @(negedge clock);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
